// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch-op encodings, the NOP word and the
// fetch FSM state type.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'b100101;
  localparam logic [5:0] OP_CALL = 6'b100110;
  localparam logic [5:0] OP_BR   = 6'b000100;

  localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'b0};

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'b000,
    BR_MI     = 3'b001,
    BR_PL     = 3'b010,
    BR_Z      = 3'b011,
    BR_NONE   = 3'b100
  } br_op_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_LATCH,
    ST_READY
  } fetch_state_e;

  // Word-aligned byte offset from a 16-bit signed word displacement.
  function automatic logic [31:0] word_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC selection: resolves brOp against rs_data and picks
// the sequential or branch-target address (32-bit wrap-around arithmetic).
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [2:0]  brOp,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        taken
);

  logic [31:0] seq;
  logic [31:0] tgt;

  always_comb begin
    seq   = pc + 32'd4;
    tgt   = seq + word_offset(imm);
    taken = 1'b0;
    case (br_op_e'(brOp))
      BR_ALWAYS: taken = 1'b1;
      BR_MI:     taken = rs_data[31];
      BR_PL:     taken = ~rs_data[31] && (rs_data != '0);
      BR_Z:      taken = (rs_data == '0);
      default:   taken = 1'b0;
    endcase
    next_pc = taken ? tgt : seq;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem read, IR and field decode.
// Optional CALL link output is enabled with `define CALL_LINK_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               updPC,
  input  logic [2:0]         brOp,
  input  logic [31:0]        rs_data,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc,
  output logic               ins_valid,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         func,
  output logic [15:0]        imm
`ifdef CALL_LINK_EN
  ,
  output logic               link_we,
  output logic [31:0]        link_data
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         valid_q;
  logic         imem_en_q;
  logic         prev_upd_q;

  logic         upd_edge;
  logic [31:0]  pc_seq;
  logic [31:0]  pc_d;
  logic [31:0]  br_next_pc;
  logic         br_taken;
  logic [2:0]   br_op_eff;

  assign upd_edge = updPC & ~prev_upd_q;
  assign pc_seq   = pc_q + 32'd4;

`ifdef CALL_LINK_EN
  logic        link_we_q;
  logic [31:0] link_data_q;
  logic        is_call;

  assign is_call   = (ir_q[31:26] == OP_CALL);
  assign br_op_eff = is_call ? BR_ALWAYS : brOp;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
`else
  assign br_op_eff = brOp;
`endif

  branch_resolve u_branch_resolve (
    .pc      (pc_q),
    .imm     (ir_q[15:0]),
    .brOp    (br_op_eff),
    .rs_data (rs_data),
    .next_pc (br_next_pc),
    .taken   (br_taken)
  );

  assign pc_d = br_taken ? br_next_pc : pc_seq;

  always_ff @(posedge clk) begin
    prev_upd_q <= updPC;
`ifdef CALL_LINK_EN
    link_we_q  <= 1'b0;
`endif
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      valid_q    <= 1'b0;
      imem_en_q  <= 1'b0;
      prev_upd_q <= 1'b0;
`ifdef CALL_LINK_EN
      link_data_q <= '0;
`endif
    end else begin
      case (state_q)
        // Reset leaves imem_en low, so the first FETCH after reset spends one
        // cycle raising it; fetches launched from READY enter with it already set.
        ST_FETCH: begin
          if (imem_en_q) begin
            imem_en_q <= 1'b0;
            state_q   <= ST_LATCH;
          end else begin
            imem_en_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          ir_q    <= imem_data;
          valid_q <= 1'b1;
          state_q <= ST_READY;
        end
        ST_READY: begin
          if (upd_edge) begin
            pc_q      <= pc_d;
            valid_q   <= 1'b0;
            imem_en_q <= 1'b1;
            state_q   <= ST_FETCH;
`ifdef CALL_LINK_EN
            if (is_call) begin
              link_we_q   <= 1'b1;
              link_data_q <= pc_seq;
            end
`endif
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign ins_valid = valid_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign func      = ir_q[4:0];
  assign imm       = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of branch vectors plus hand sequences
// for updPC hold/re-edge, mid-fetch reset and CALL linking.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        updPC;
  logic [2:0]  brOp;
  logic [31:0] rs_data;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        ins_valid;
  logic [5:0]  opcode;
  logic [4:0]  f_rs, f_rt, f_rd, f_func;
  logic [15:0] f_imm;
`ifdef CALL_LINK_EN
  logic        link_we;
  logic [31:0] link_data;
`endif

  logic [31:0] imem [1024];
  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .updPC     (updPC),
    .brOp      (brOp),
    .rs_data   (rs_data),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc        (pc),
    .ins_valid (ins_valid),
    .opcode    (opcode),
    .rs        (f_rs),
    .rt        (f_rt),
    .rd        (f_rd),
    .func      (f_func),
    .imm       (f_imm)
`ifdef CALL_LINK_EN
    ,
    .link_we   (link_we),
    .link_data (link_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_data <= imem[imem_addr];
  end

  typedef struct {
    logic [2:0]  br;
    logic [31:0] rsd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ir(input string tag, input logic [31:0] exp_pc);
    logic [31:0] w;
    w = imem[exp_pc[11:2]];
    chk({tag, " pc"},     pc,        exp_pc);
    chk({tag, " valid"},  {31'b0, ins_valid}, 32'd1);
    chk({tag, " opcode"}, {26'b0, opcode}, {26'b0, w[31:26]});
    chk({tag, " rs"},     {27'b0, f_rs},   {27'b0, w[25:21]});
    chk({tag, " rt"},     {27'b0, f_rt},   {27'b0, w[20:16]});
    chk({tag, " rd"},     {27'b0, f_rd},   {27'b0, w[15:11]});
    chk({tag, " func"},   {27'b0, f_func}, {27'b0, w[4:0]});
    chk({tag, " imm"},    {16'b0, f_imm},  {16'b0, w[15:0]});
  endtask

  // Called at a negedge while READY; returns at the negedge of cycle T+3.
  task automatic do_update(input string tag, input logic [2:0] op,
                           input logic [31:0] rsd, input logic [31:0] exp_pc);
    updPC = 1'b1; brOp = op; rs_data = rsd;
    @(posedge clk);
    @(negedge clk);
    updPC = 1'b0; brOp = 3'b000; rs_data = 32'h8000_0000;
    chk({tag, " valid T+1"}, {31'b0, ins_valid}, 32'd0);
    @(negedge clk);
    chk({tag, " valid T+2"}, {31'b0, ins_valid}, 32'd0);
    @(negedge clk);
    check_ir(tag, exp_pc);
  endtask

  // Applies reset from a negedge and follows the refetch from address 0.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rst pc"},     pc, 32'h0);
    chk({tag, " rst valid"},  {31'b0, ins_valid}, 32'd0);
    chk({tag, " rst imem_en"}, {31'b0, imem_en}, 32'd0);
    chk({tag, " rst opcode"}, {26'b0, opcode}, 32'h25);
    chk({tag, " rst imm"},    {16'b0, f_imm}, 32'h0);
`ifdef CALL_LINK_EN
    chk({tag, " rst link_we"},   {31'b0, link_we}, 32'd0);
    chk({tag, " rst link_data"}, link_data, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk({tag, " c1 valid"},   {31'b0, ins_valid}, 32'd0);
    chk({tag, " c1 imem_en"}, {31'b0, imem_en}, 32'd1);
    @(negedge clk);
    chk({tag, " c2 valid"},   {31'b0, ins_valid}, 32'd0);
    chk({tag, " c2 imem_en"}, {31'b0, imem_en}, 32'd0);
    @(negedge clk);
    check_ir({tag, " c3"}, 32'h0);
    chk({tag, " c3 opcode"}, {26'b0, opcode}, 32'h01);
    chk({tag, " c3 imm"},    {16'b0, f_imm}, 32'h0005);
  endtask

  initial begin
    rst = 1'b1; updPC = 1'b0; brOp = 3'b100; rs_data = '0;
    for (int unsigned i = 0; i < 1024; i++) imem[i] = 32'hA5A5_0000 | i;
    imem[0]    = 32'h0420_0005;
    imem[1]    = 32'h08A3_2814;
    imem[2]    = 32'h1040_FFFE;
    imem[3]    = 32'h0C61_0010;
    imem[4]    = 32'h1082_0004;
    imem[5]    = 32'h0CA3_FFF9;
    imem[20]   = 32'h0862_FFF0;
    imem[21]   = 32'h0841_0002;
    imem[24]   = 32'h1000_FFEA;
    imem[1023] = 32'h9400_0100;

    vecs[0]  = '{3'b100, 32'h0,          32'h0000_0004};
    vecs[1]  = '{3'b100, 32'h0,          32'h0000_0008};
    vecs[2]  = '{3'b011, 32'h0,          32'h0000_0004};
    vecs[3]  = '{3'b100, 32'h0,          32'h0000_0008};
    vecs[4]  = '{3'b011, 32'h5,          32'h0000_000C};
    vecs[5]  = '{3'b001, 32'h8000_0000,  32'h0000_0050};
    vecs[6]  = '{3'b010, 32'h8000_0000,  32'h0000_0054};
    vecs[7]  = '{3'b010, 32'h1,          32'h0000_0060};
    vecs[8]  = '{3'b000, 32'hDEAD_BEEF,  32'h0000_000C};
    vecs[9]  = '{3'b010, 32'h0,          32'h0000_0010};
    vecs[10] = '{3'b001, 32'h7FFF_FFFF,  32'h0000_0014};
    vecs[11] = '{3'b000, 32'h0,          32'hFFFF_FFFC};
    vecs[12] = '{3'b101, 32'h0,          32'h0000_0000};

    do_reset("init");

    for (int i = 0; i < 13; i++)
      do_update($sformatf("v%0d", i), vecs[i].br, vecs[i].rsd, vecs[i].exp_pc);

    // updPC held high for five cycles: exactly one advance 0 -> 4.
    updPC = 1'b1; brOp = 3'b100;
    repeat (5) @(posedge clk);
    @(negedge clk);
    updPC = 1'b0;
    repeat (2) @(negedge clk);
    check_ir("hold", 32'h4);

    // Second rising edge lands while LATCH and must be dropped: 4 -> 8 only.
    updPC = 1'b1; brOp = 3'b100;
    @(posedge clk);
    @(negedge clk);
    updPC = 1'b0;
    @(negedge clk);
    updPC = 1'b1;
    @(negedge clk);
    updPC = 1'b0;
    repeat (3) @(negedge clk);
    check_ir("relatch", 32'h8);

    // Reset asserted during LATCH of the fetch from 0xC.
    updPC = 1'b1; brOp = 3'b100;
    @(posedge clk);
    @(negedge clk);
    updPC = 1'b0;
    @(negedge clk);
    do_reset("midfetch");

    // Walk to 0x10 and place a CALL there (imm 8 -> target 0x34).
    imem[4] = 32'h9800_0008;
    do_update("nav1", 3'b100, 32'h0, 32'h4);
    do_update("nav2", 3'b100, 32'h0, 32'h8);
    do_update("nav3", 3'b011, 32'h5, 32'hC);
    do_update("nav4", 3'b010, 32'h0, 32'h10);
`ifdef CALL_LINK_EN
    updPC = 1'b1; brOp = 3'b100; rs_data = '0;
    @(posedge clk);
    @(negedge clk);
    updPC = 1'b0;
    chk("call link_we T+1",   {31'b0, link_we}, 32'd1);
    chk("call link_data T+1", link_data, 32'h14);
    @(negedge clk);
    chk("call link_we T+2",   {31'b0, link_we}, 32'd0);
    @(negedge clk);
    check_ir("call", 32'h34);
    chk("call link_we T+3",   {31'b0, link_we}, 32'd0);
`else
    do_update("call", 3'b100, 32'h0, 32'h14);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
